ex_wb_pipeline: RTL
===================

Name: ex_wb_pipeline

Overview:
- Execute-side consumer of the decode/execute pipeline control bundle (werf, wb_sel, rd); owns the EX→WB boundary.
- Buffers completed EX results in a 2-entry queue with valid/ready handshake, selects writeback data, and drives the integer/FP register-file write port.
- Provides a same-cycle forwarding lookup into buffered, not-yet-retired results, and a retired-write counter.

Parameters:
- XLEN, 32, data width of the ALU result, memory read data and writeback data.
- RADDR_W, 5, register address width.
- CNT_W, 32, width of the retired-write counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX result beat valid.
- ex_ready  out  1  queue can accept a beat.
- ex_alu_result  in  XLEN  ALU/FPU result.
- ex_mem_rdata  in  XLEN  load data.
- ex_rd  in  RADDR_W  destination register.
- ex_dest_fp  in  1  1 = FP register file, 0 = integer register file.
- ex_werf  in  1  register write enable.
- ex_wb_sel  in  1  0 = ALU result, 1 = memory data.
- flush  in  1  discard all buffered beats.
- rf_ready  in  1  register-file write port accepts this cycle.
- rf_we  out  1  register-file write strobe.
- rf_fp  out  1  target file select.
- rf_waddr  out  RADDR_W  write address.
- rf_wdata  out  XLEN  write data.
- fwd_addr  in  RADDR_W  lookup address.
- fwd_fp  in  1  lookup file select.
- fwd_hit  out  1  matching buffered write exists.
- fwd_data  out  XLEN  data of the matching entry.
- retired_cnt  out  CNT_W  count of completed register writes.

Behaviour:
- Reset (rst_n low, asynchronous): queue empty, count = 0, rd/wr pointers = 0, retired_cnt = 0. Outputs: ex_ready = 1, rf_we = 0, rf_fp = 0, rf_waddr = 0, rf_wdata = 0, fwd_hit = 0, fwd_data = 0.
- Reset asserted mid-operation drops all entries with no writes issued. Behaviour on release is identical to power-up.
- Push: ex_valid && ex_ready captures the entry at the tail.
  - wdata = ex_wb_sel ? ex_mem_rdata : ex_alu_result, resolved at push.
  - Stored write flag = ex_werf && !(ex_rd == 0 && !ex_dest_fp). Integer x0 writes are squashed; FP f0 is writable.
- ex_ready = (count != 2). This is a function of registered state only, with no combinational path from rf_ready.
- Head presentation: when count > 0, rf_fp/rf_waddr/rf_wdata show the head fields and rf_we = head write flag. When empty, rf_we = 0 and the data outputs hold their last values.
- Latency: a beat pushed in cycle N is visible on the rf_* outputs in cycle N+1 if the queue was empty.
- Pop: when count > 0 && (rf_ready || !head write flag).
  - Non-writing entries retire without waiting for rf_ready.
  - retired_cnt increments by 1 only on pops with rf_we = 1. It wraps modulo 2^CNT_W.
- Simultaneous push and pop: count is unchanged, and both pointers advance (mod 2). Push at count 2 cannot occur because ex_ready = 0. Pop at count 0 cannot occur.
- Flush (synchronous): next cycle count = 0 and pointers = 0.
  - Flush overrides a same-cycle push and pop: no entry captured, no retire counted.
  - rf_we may still be 1 in the flush cycle, since it is combinational from the head. The register file must gate on its own flush.
- Forwarding (combinational): compare fwd_addr/fwd_fp against valid entries with the write flag set.
  - The newest (tail-1) match wins over the older one.
  - fwd_hit = 0 when there is no match or when fwd_addr = 0 with fwd_fp = 0. In that case fwd_data = 0.

Decomposition:
- Shared package ex_wb_pkg holds:
  - typedef wb_entry_t {wdata[XLEN], rd[RADDR_W], fp, we}.
  - Constants WB_SEL_ALU = 0 and WB_SEL_MEM = 1.
  - Constant WB_DEPTH = 2.
- One natural sub-module, wb_skid_queue: a 2-entry storage with pointers, count, push/pop/flush, and head/entry views.
- The wdata mux, x0 squash, forward compare and retire counter stay in the top level.

Test Plan:
- Reset release, then one beat (alu = 32'h0000_00AA, wb_sel = 0, rd = 5, werf = 1, rf_ready = 1) -> next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 32'hAA; retired_cnt = 1 one cycle later.
- rf_ready = 0 while pushing beats A (rd 1), B (rd 2), C (rd 3) -> ex_ready drops after B and C stalls. Raise rf_ready -> writes appear in order 1, 2, 3 with no loss or duplication, and retired_cnt = 3.
- Integer rd = 0 with werf = 1 -> rf_we = 0 and retired_cnt unchanged. FP rd = 0 with fp = 1 and wb_sel = 1, mem = 32'h3F80_0000 -> rf_we = 1, rf_fp = 1, rf_wdata = 32'h3F80_0000.
- Two buffered writes to x7 (older 32'h11, newer 32'h22) with rf_ready = 0, then lookup fwd_addr = 7, fwd_fp = 0 -> fwd_hit = 1, fwd_data = 32'h22. Lookup with fwd_fp = 1 -> fwd_hit = 0.
- Queue full, then flush asserted together with ex_valid and rf_ready -> next cycle count = 0, ex_ready = 1, rf_we = 0, retired_cnt unchanged.
- Drop rst_n asynchronously between clock edges while 2 entries are pending -> all outputs reach their reset values immediately. After release, no stale write is issued.

Source files
------------

// File: rtl/ex_wb_pkg.sv
// rtl/ex_wb_pkg.sv - shared types and constants for the EX->WB boundary
package ex_wb_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int WB_DEPTH    = 2;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef struct packed {
    logic [XLEN_DEF-1:0]    wdata;
    logic [RADDR_W_DEF-1:0] rd;
    logic                   fp;
    logic                   we;
  } wb_entry_t;

  // Integer x0 is hardwired to zero, so writes to it are dropped; FP f0 is a real register.
  function automatic logic wb_writes(input logic werf, input logic [RADDR_W_DEF-1:0] rd,
                                     input logic fp);
    return werf && !((rd == '0) && !fp);
  endfunction

endpackage

// File: rtl/wb_skid_queue.sv
// rtl/wb_skid_queue.sv - two-entry result queue with pointers, count and flush
module wb_skid_queue
  import ex_wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  wb_entry_t push_entry,
  output wb_entry_t head,
  output wb_entry_t entries [WB_DEPTH],
  output logic [1:0] count,
  output logic      wr_ptr,
  output logic      rd_ptr
);

  assign head = entries[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WB_DEPTH; i++) entries[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ex_wb_pipeline.sv
// rtl/ex_wb_pipeline.sv - EX result buffering, writeback select, forwarding and retire count
module ex_wb_pipeline
  import ex_wb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ex_valid,
  output logic               ex_ready,
  input  logic [XLEN-1:0]    ex_alu_result,
  input  logic [XLEN-1:0]    ex_mem_rdata,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_dest_fp,
  input  logic               ex_werf,
  input  logic               ex_wb_sel,
  input  logic               flush,
  input  logic               rf_ready,
  output logic               rf_we,
  output logic               rf_fp,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  input  logic [RADDR_W-1:0] fwd_addr,
  input  logic               fwd_fp,
  output logic               fwd_hit,
  output logic [XLEN-1:0]    fwd_data,
  output logic [CNT_W-1:0]   retired_cnt
);

  wb_entry_t          in_entry;
  wb_entry_t          head;
  wb_entry_t          entries [WB_DEPTH];
  logic [1:0]         count;
  logic               wr_ptr;
  logic               rd_ptr;
  logic               newest_ptr;
  logic               not_empty;
  logic               push;
  logic               pop;
  logic               hold_fp;
  logic [RADDR_W-1:0] hold_waddr;
  logic [XLEN-1:0]    hold_wdata;

  assign in_entry.wdata = (ex_wb_sel == WB_SEL_MEM) ? ex_mem_rdata : ex_alu_result;
  assign in_entry.rd    = ex_rd;
  assign in_entry.fp    = ex_dest_fp;
  assign in_entry.we    = wb_writes(ex_werf, ex_rd, ex_dest_fp);

  assign not_empty = (count != 2'd0);
  assign ex_ready  = (count != 2'(WB_DEPTH));
  assign push      = ex_valid && ex_ready;
  assign pop       = not_empty && (rf_ready || !head.we);

  wb_skid_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_entry (in_entry),
    .head       (head),
    .entries    (entries),
    .count      (count),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr)
  );

  // Data outputs keep the last presented head while the queue sits empty.
  assign rf_we    = not_empty && head.we;
  assign rf_fp    = not_empty ? head.fp    : hold_fp;
  assign rf_waddr = not_empty ? head.rd    : hold_waddr;
  assign rf_wdata = not_empty ? head.wdata : hold_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_fp     <= 1'b0;
      hold_waddr  <= '0;
      hold_wdata  <= '0;
      retired_cnt <= '0;
    end else begin
      if (not_empty) begin
        hold_fp    <= head.fp;
        hold_waddr <= head.rd;
        hold_wdata <= head.wdata;
      end
      if (pop && head.we && !flush) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  assign newest_ptr = wr_ptr - 1'b1;

  function automatic logic fwd_match(input wb_entry_t e, input logic [RADDR_W-1:0] addr,
                                     input logic fp);
    return e.we && (e.rd == addr) && (e.fp == fp);
  endfunction

  // Older entry is checked first so the newest match overrides it.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (!((fwd_addr == '0) && !fwd_fp)) begin
      if ((count == 2'd2) && fwd_match(entries[rd_ptr], fwd_addr, fwd_fp)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[rd_ptr].wdata;
      end
      if (not_empty && fwd_match(entries[newest_ptr], fwd_addr, fwd_fp)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[newest_ptr].wdata;
      end
    end
  end

endmodule
